// File: rtl/l2_ctl_pkg.sv
// l2_ctl_pkg: shared widths, state encodings and grant type for the L2 cache sequencer
package l2_ctl_pkg;
    localparam int AW = 26;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int LOOKUP_LAT_DEF = 1;
    typedef logic [3:0] state_t;
    localparam state_t S_IDLE    = 4'd0;
    localparam state_t S_LOOKUP  = 4'd1;
    localparam state_t S_MEMRD   = 4'd2;
    localparam state_t S_FILL    = 4'd3;
    localparam state_t S_WRUPD   = 4'd4;
    localparam state_t S_MEMWR   = 4'd5;
    localparam state_t S_FLUSHOP = 4'd6;
    localparam state_t S_INVOP   = 4'd7;
    localparam state_t S_DONE    = 4'd8;
    typedef enum logic [1:0] {G_NONE, G_FLUSH, G_INV, G_CPU} grant_t;
endpackage

// File: rtl/l2_ctl_arb.sv
// l2_ctl_arb: flush-pending latch and fixed-priority grant (flush > invalidate > cpu)
module l2_ctl_arb
    import l2_ctl_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   flush_done,
    input  logic   idle,
    input  logic   invreq,
    input  logic   cpureq,
    output logic   pend,
    output grant_t gnt
);
    // a new pulse arriving during the flush cycle itself must not be lost
    always_ff @(posedge clk)
        if (rst) pend <= 1'b0;
        else     pend <= flush | (pend & ~flush_done);

    always_comb
        gnt = !idle          ? G_NONE  :
              (pend | flush) ? G_FLUSH :
              invreq         ? G_INV   :
              cpureq         ? G_CPU   : G_NONE;
endmodule

// File: rtl/l2_cache_ctl.sv
// l2_cache_ctl: L2 array sequencer (flush/snoop/cpu, read fill, write-through); L2_WRITE_ALLOCATE_EN enables full-mask write-miss allocate
module l2_cache_ctl
    import l2_ctl_pkg::*;
#(
    parameter int LOOKUP_LAT = LOOKUP_LAT_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CPUREQ,
    input  logic          CPUWE,
    input  logic [AW-1:0] CPUA,
    input  logic [DW-1:0] CPUWD,
    input  logic [MW-1:0] CPUM,
    output logic          CPUACK,
    output logic [DW-1:0] CPURDD,
    input  logic          FLUSH,
    output logic          FLUSHBUSY,
    input  logic          INVREQ,
    input  logic [AW-1:0] INVA,
    output logic          INVACK,
    output logic [AW-1:0] CRDA,
    input  logic [DW-1:0] CRDD,
    input  logic          CMATCH,
    output logic [AW-1:0] CWRA,
    output logic [DW-1:0] CWRD,
    output logic [MW-1:0] CWRM,
    output logic          CTS,
    output logic          CWR,
    output logic          CCLR,
    output logic          CALL,
    output logic          MREQ,
    output logic          MWE,
    output logic [AW-1:0] MA,
    output logic [DW-1:0] MWD,
    output logic [MW-1:0] MM,
    input  logic          MACK,
    input  logic [DW-1:0] MRDD
);
    state_t        state;
    logic [1:0]    cnt;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] rdd;
    logic [MW-1:0] m;
    logic          we;
    logic          alloc;
    logic          ack;
    logic          pend;
    logic          lookup_done;
    logic          alloc_miss;
    grant_t        gnt;

    l2_ctl_arb u_arb (
        .clk        (CLK),
        .rst        (RST),
        .flush      (FLUSH),
        .flush_done (state == S_FLUSHOP),
        .idle       (state == S_IDLE),
        .invreq     (INVREQ),
        .cpureq     (CPUREQ),
        .pend       (pend),
        .gnt        (gnt)
    );

`ifdef L2_WRITE_ALLOCATE_EN
    assign alloc_miss = (m == 4'hF);
`else
    assign alloc_miss = 1'b0;
`endif

    assign lookup_done = (cnt == 2'(LOOKUP_LAT));

    always_ff @(posedge CLK)
        if (RST) begin
            state <= S_IDLE;
            cnt   <= '0;
            addr  <= '0;
            wd    <= '0;
            rdd   <= '0;
            m     <= '0;
            we    <= 1'b0;
            alloc <= 1'b0;
            ack   <= 1'b0;
        end else begin
            ack <= 1'b0;
            case (state)
                S_IDLE:
                    case (gnt)
                        G_FLUSH: state <= S_FLUSHOP;
                        G_INV:   state <= S_INVOP;
                        G_CPU: begin
                            state <= S_LOOKUP;
                            addr  <= CPUA;
                            wd    <= CPUWD;
                            m     <= CPUM;
                            we    <= CPUWE;
                            cnt   <= '0;
                        end
                        default: state <= S_IDLE;
                    endcase
                S_LOOKUP:
                    if (!lookup_done) cnt <= cnt + 2'd1;
                    else if (!we && CMATCH) begin
                        ack   <= 1'b1;
                        rdd   <= CRDD;
                        state <= S_DONE;
                    end
                    else if (!we) state <= S_MEMRD;
                    else if (CMATCH || alloc_miss) begin
                        alloc <= !CMATCH;
                        state <= S_WRUPD;
                    end
                    else state <= S_MEMWR;
                S_MEMRD:
                    if (MACK) begin
                        ack   <= 1'b1;
                        rdd   <= MRDD;
                        state <= S_FILL;
                    end
                S_FILL:  state <= S_DONE;
                S_WRUPD: state <= S_MEMWR;
                S_MEMWR:
                    if (MACK) begin
                        ack   <= 1'b1;
                        state <= S_DONE;
                    end
                default: state <= S_IDLE;
            endcase
        end

    assign CPUACK    = ack;
    assign CPURDD    = rdd;
    assign FLUSHBUSY = pend | (state == S_FLUSHOP);
    assign INVACK    = (state == S_INVOP);
    assign CRDA      = addr;
    assign CWRA      = (state == S_INVOP) ? INVA : addr;
    assign CWR       = (state == S_FILL) | (state == S_WRUPD);
    assign CWRD      = (state == S_FILL) ? rdd : (state == S_WRUPD) ? wd : '0;
    assign CWRM      = (state == S_FILL) ? 4'hF : (state == S_WRUPD) ? m : '0;
    assign CTS       = (state == S_FILL) | ((state == S_WRUPD) & alloc);
    assign CCLR      = (state == S_FLUSHOP) | (state == S_INVOP);
    assign CALL      = (state == S_FLUSHOP);
    assign MREQ      = (state == S_MEMRD) | (state == S_MEMWR);
    assign MWE       = (state == S_MEMWR);
    assign MA        = MREQ ? addr : '0;
    assign MWD       = MWE ? wd : '0;
    assign MM        = MWE ? m : '0;
endmodule

// File: tb/tb_l2_cache_ctl.sv
// tb_l2_cache_ctl: directed cycle-exact checks of the L2 sequencer at LOOKUP_LAT=1
module tb_l2_cache_ctl;
    logic        CLK = 1'b0, RST = 1'b1;
    logic        CPUREQ = 0, CPUWE = 0, FLUSH = 0, INVREQ = 0, CMATCH = 0, MACK = 0;
    logic [25:0] CPUA = '0, INVA = '0;
    logic [31:0] CPUWD = '0, CRDD = '0, MRDD = '0;
    logic [3:0]  CPUM = '0;
    logic        CPUACK, FLUSHBUSY, INVACK, CTS, CWR, CCLR, CALL, MREQ, MWE;
    logic [31:0] CPURDD, CWRD, MWD;
    logic [25:0] CRDA, CWRA, MA;
    logic [3:0]  CWRM, MM;
    int          errors = 0, checks = 0;

    l2_cache_ctl dut (
        .CLK(CLK), .RST(RST), .CPUREQ(CPUREQ), .CPUWE(CPUWE), .CPUA(CPUA),
        .CPUWD(CPUWD), .CPUM(CPUM), .CPUACK(CPUACK), .CPURDD(CPURDD),
        .FLUSH(FLUSH), .FLUSHBUSY(FLUSHBUSY), .INVREQ(INVREQ), .INVA(INVA),
        .INVACK(INVACK), .CRDA(CRDA), .CRDD(CRDD), .CMATCH(CMATCH),
        .CWRA(CWRA), .CWRD(CWRD), .CWRM(CWRM), .CTS(CTS), .CWR(CWR),
        .CCLR(CCLR), .CALL(CALL), .MREQ(MREQ), .MWE(MWE), .MA(MA),
        .MWD(MWD), .MM(MM), .MACK(MACK), .MRDD(MRDD)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // strobes packed as {CPUACK,INVACK,FLUSHBUSY,MREQ,MWE,CWR,CCLR,CALL,CTS}
    function automatic logic [31:0] strobes();
        return {23'd0, CPUACK, INVACK, FLUSHBUSY, MREQ, MWE, CWR, CCLR, CALL, CTS};
    endfunction

    task automatic cpu_req(input logic wr, input logic [25:0] a, input logic [31:0] d, input logic [3:0] msk);
        CPUREQ = 1; CPUWE = wr; CPUA = a; CPUWD = d; CPUM = msk;
    endtask

    initial begin
        tick; tick;
        chk("rst_strobes", strobes(), 32'h0);
        chk("rst_crda", {6'd0, CRDA}, 32'h0);
        chk("rst_cpurdd", CPURDD, 32'h0);
        RST = 0;
        tick;
        // read miss with 4-cycle memory latency
        CMATCH = 0;
        cpu_req(0, 26'h0001000, 32'h0, 4'h0);
        tick;
        chk("rdmiss_crda", {6'd0, CRDA}, 32'h0001000);
        chk("rdmiss_nomreq_c1", {31'd0, MREQ}, 32'h0);
        tick;
        chk("rdmiss_nomreq_c2", {31'd0, MREQ}, 32'h0);
        tick;
        chk("rdmiss_mreq", {29'd0, MREQ, MWE, CWR}, 32'b100);
        chk("rdmiss_ma", {6'd0, MA}, 32'h0001000);
        tick; tick; tick;
        chk("rdmiss_mreq_held", {30'd0, MREQ, CPUACK}, 32'b10);
        MACK = 1; MRDD = 32'hDEADBEEF;
        tick;
        MACK = 0; MRDD = 32'h0;
        chk("fill_strobes", {28'd0, CWR, CTS, CPUACK, MREQ}, 32'b1110);
        chk("fill_cwrm", {28'd0, CWRM}, 32'hF);
        chk("fill_cwra", {6'd0, CWRA}, 32'h0001000);
        chk("fill_cwrd", CWRD, 32'hDEADBEEF);
        chk("fill_cpurdd", CPURDD, 32'hDEADBEEF);
        CPUREQ = 0;
        tick;
        chk("fill_done", {30'd0, CPUACK, CWR}, 32'h0);
        tick;
        // repeat read hits
        CMATCH = 1; CRDD = 32'hDEADBEEF;
        cpu_req(0, 26'h0001000, 32'h0, 4'h0);
        tick;
        chk("hit_c1", {30'd0, CPUACK, MREQ}, 32'h0);
        tick;
        chk("hit_c2", {30'd0, CPUACK, MREQ}, 32'h0);
        tick;
        chk("hit_c3", {30'd0, CPUACK, MREQ}, 32'b10);
        chk("hit_cpurdd", CPURDD, 32'hDEADBEEF);
        CPUREQ = 0;
        tick;
        chk("hit_done", {31'd0, CPUACK}, 32'h0);
        tick;
        // write hit, partial mask
        CMATCH = 1;
        cpu_req(1, 26'h0001000, 32'h12345678, 4'b0011);
        tick; tick; tick;
        chk("wrhit_upd", {28'd0, CWR, CTS, MREQ, CPUACK}, 32'b1000);
        chk("wrhit_cwrm", {28'd0, CWRM}, 32'h3);
        chk("wrhit_cwrd", CWRD, 32'h12345678);
        chk("wrhit_cwra", {6'd0, CWRA}, 32'h0001000);
        tick;
        chk("wrhit_memwr", {29'd0, MREQ, MWE, CWR}, 32'b110);
        chk("wrhit_mm", {28'd0, MM}, 32'h3);
        chk("wrhit_mwd", MWD, 32'h12345678);
        chk("wrhit_ma", {6'd0, MA}, 32'h0001000);
        MACK = 1;
        tick;
        MACK = 0;
        chk("wrhit_ack", {30'd0, CPUACK, MREQ}, 32'b10);
        CPUREQ = 0;
        tick;
        chk("wrhit_ack_pulse", {31'd0, CPUACK}, 32'h0);
        // write miss, full mask
        CMATCH = 0;
        cpu_req(1, 26'h0002000, 32'hA5A5A5A5, 4'hF);
        tick; tick; tick;
`ifdef L2_WRITE_ALLOCATE_EN
        chk("wrmiss_alloc", {29'd0, CWR, CTS, MREQ}, 32'b110);
        chk("wrmiss_alloc_cwrd", CWRD, 32'hA5A5A5A5);
        tick;
`else
        chk("wrmiss_noalloc", {29'd0, CWR, CTS, MREQ}, 32'b001);
`endif
        chk("wrmiss_memwr", {30'd0, MREQ, MWE}, 32'b11);
        chk("wrmiss_mm", {28'd0, MM}, 32'hF);
        MACK = 1;
        tick;
        MACK = 0;
        chk("wrmiss_ack", {31'd0, CPUACK}, 32'h1);
        CPUREQ = 0;
        tick;
        // partial-mask write miss never allocates
        cpu_req(1, 26'h0002004, 32'h00000055, 4'h1);
        tick; tick; tick;
        chk("wrpart_nocwr", {29'd0, CWR, MREQ, MWE}, 32'b011);
        MACK = 1;
        tick;
        MACK = 0;
        chk("wrpart_ack", {31'd0, CPUACK}, 32'h1);
        CPUREQ = 0;
        tick;
        // flush pulse during a read miss
        cpu_req(0, 26'h0003000, 32'h0, 4'h0);
        tick; tick; tick;
        chk("flmiss_mreq", {31'd0, MREQ}, 32'h1);
        FLUSH = 1;
        tick;
        FLUSH = 0;
        chk("flmiss_busy", {29'd0, FLUSHBUSY, MREQ, CCLR}, 32'b110);
        MACK = 1; MRDD = 32'h11112222;
        tick;
        MACK = 0;
        chk("flmiss_fill", {27'd0, FLUSHBUSY, CWR, CPUACK, CCLR, CALL}, 32'b11100);
        chk("flmiss_cwrd", CWRD, 32'h11112222);
        CPUREQ = 0;
        tick;
        chk("flmiss_done", {30'd0, FLUSHBUSY, CCLR}, 32'b10);
        tick;
        chk("flmiss_idle", {30'd0, FLUSHBUSY, CCLR}, 32'b10);
        tick;
        chk("flmiss_flushop", {29'd0, FLUSHBUSY, CCLR, CALL}, 32'b111);
        tick;
        chk("flmiss_after", {29'd0, FLUSHBUSY, CCLR, CALL}, 32'b000);
        // flush, invalidate and cpu together
        FLUSH = 1; INVREQ = 1; INVA = 26'h0000040;
        CMATCH = 1; CRDD = 32'h0BADF00D;
        cpu_req(0, 26'h0001000, 32'h0, 4'h0);
        tick;
        FLUSH = 0;
        chk("tri_flush", {28'd0, CCLR, CALL, INVACK, CPUACK}, 32'b1100);
        chk("tri_flush_busy", {31'd0, FLUSHBUSY}, 32'h1);
        tick;
        chk("tri_gap", {29'd0, CCLR, INVACK, FLUSHBUSY}, 32'b000);
        tick;
        chk("tri_inv", {29'd0, CCLR, CALL, INVACK}, 32'b101);
        chk("tri_inv_cwra", {6'd0, CWRA}, 32'h0000040);
        INVREQ = 0;
        tick;
        chk("tri_inv_pulse", {30'd0, INVACK, CCLR}, 32'h0);
        tick;
        chk("tri_cpu_crda", {6'd0, CRDA}, 32'h0001000);
        tick; tick;
        chk("tri_cpu_ack", {31'd0, CPUACK}, 32'h1);
        chk("tri_cpu_rdd", CPURDD, 32'h0BADF00D);
        CPUREQ = 0;
        tick; tick;
        // reset while memory request outstanding
        CMATCH = 0;
        cpu_req(0, 26'h0004000, 32'h0, 4'h0);
        tick; tick; tick;
        chk("rstmid_mreq", {31'd0, MREQ}, 32'h1);
        RST = 1;
        tick;
        chk("rstmid_strobes", strobes(), 32'h0);
        chk("rstmid_crda", {6'd0, CRDA}, 32'h0);
        chk("rstmid_ma", {6'd0, MA}, 32'h0);
        RST = 0; CPUREQ = 0;
        tick;
        chk("rstmid_idle", strobes(), 32'h0);
        tick;
        chk("rstmid_noack", {30'd0, CPUACK, MREQ}, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/l2_cache_ctl.md
# l2_cache_ctl

Sequencer for the 8-way L2 cache array. Owns the array's lookup and write/clear ports; arbitrates between whole-cache flush, single-line snoop invalidate and CPU read/write requests. Services read misses from backing memory with line fill, and writes through to memory with hit update. Sits between the CPU bus interface and the memory controller.

## Interface
- LOOKUP_LAT, default 1: cycles from CRDA valid to CRDD/CMATCH valid (1..3).
- CLK  in  1  system clock; single clock domain.
- RST  in  1  synchronous, active-high reset.
- CPUREQ  in  1  CPU request; held with CPUA/CPUWD/CPUM/CPUWE stable until CPUACK.
- CPUWE  in  1  1 = write, 0 = read.
- CPUA  in  26  longword address [27:2].
- CPUWD  in  32  write data.
- CPUM  in  4  write byte mask.
- CPUACK  out  1  one-cycle completion pulse.
- CPURDD  out  32  read data, valid with CPUACK on reads.
- FLUSH  in  1  pulse: invalidate whole cache.
- FLUSHBUSY  out  1  flush pending or in progress.
- INVREQ  in  1  snoop invalidate request; held until INVACK.
- INVA  in  26  snoop address.
- INVACK  out  1  one-cycle pulse.
- CRDA  out  26  cache lookup address.
- CRDD  in  32  cache read data.
- CMATCH  in  1  cache hit.
- CWRA  out  26  cache write/clear address.
- CWRD  out  32  cache write data.
- CWRM  out  4  cache write mask.
- CTS  out  1  tag set (allocate) qualifier.
- CWR  out  1  cache write strobe.
- CCLR  out  1  cache clear strobe.
- CALL  out  1  clear qualifier: all lines.
- MREQ  out  1  memory request; held until MACK.
- MWE  out  1  memory write.
- MA  out  26  memory address.
- MWD  out  32  memory write data.
- MM  out  4  memory byte mask.
- MACK  in  1  memory completion; ignored while MREQ low.
- MRDD  in  32  memory read data, valid with MACK.

## Operation
- States: IDLE, LOOKUP, MEMRD, FILL, WRUPD, MEMWR, FLUSHOP, INVOP, DONE.
- Reset: state IDLE, all outputs 0, flush-pending and latched address/data cleared.
- FLUSH pulse sets flush-pending in any state; FLUSHBUSY = pending | FLUSHOP.
- IDLE priority: flush-pending > INVREQ > CPUREQ. Arbitration only in IDLE; active operation never preempted.
- FLUSHOP (1 cycle): CCLR=1, CALL=1; clears pending -> IDLE.
- INVOP (1 cycle): CCLR=1, CALL=0, CWRA=INVA, INVACK=1 -> IDLE.
- CPU accept: latch CPUA/CPUWD/CPUM/CPUWE; CRDA driven from latch -> LOOKUP for LOOKUP_LAT cycles, then sample CMATCH/CRDD.
- Read hit: CPUACK=1, CPURDD=CRDD (registered) -> DONE.
- Read miss -> MEMRD: MREQ=1, MWE=0, MA=addr until MACK; capture MRDD -> FILL: CWR=1, CTS=1, CWRM=4'hF, CWRA=addr, CWRD=captured, CPUACK=1, CPURDD=captured -> DONE.
- Write: after LOOKUP, if hit -> WRUPD: CWR=1, CTS=0, CWRM=CPUM, CWRD=CPUWD (1 cycle) -> MEMWR; miss -> MEMWR directly.
- MEMWR: MREQ=1, MWE=1, MA/MWD/MM from latch until MACK; next cycle CPUACK=1 -> DONE.
- DONE (1 cycle): CPUREQ ignored; CPU drops CPUREQ here. -> IDLE.
- All C*/M* strobes are 0 outside the states named above; CRDA holds the last latch value.

## Timing
- Request accepted in cycle 0 (IDLE, CPUREQ=1); CRDA valid cycle 1; sample at cycle 1+LOOKUP_LAT.
- Read hit: CPUACK in cycle 2+LOOKUP_LAT (3 at default).
- Read miss: MREQ from cycle 2+LOOKUP_LAT; FILL/CPUACK one cycle after MACK.
- Write: CPUACK one cycle after MACK; WRUPD adds one cycle on hit.
- Flush/invalidate from IDLE: strobe in the cycle after arbitration; INVACK coincident with strobe.
- FLUSH during a miss: cache fill completes first, then flush; a line filled before flush is invalidated.
- FLUSH and INVREQ together: flush first; INVREQ then serviced (redundant but acknowledged).
- RST mid-transaction: MREQ drops next cycle; memory side tolerates abort; no CPUACK issued.

## Configuration
- L2_WRITE_ALLOCATE_EN defined: write miss with CPUM=4'hF performs WRUPD with CTS=1 (allocate) before MEMWR; partial-mask misses do not allocate.
- Undefined: write misses never touch the cache.

## Structure
- Package l2_ctl_pkg: state enum, address width constant (26), mask width, LOOKUP_LAT default.
- One sub-module l2_ctl_arb: registered flush-pending latch plus fixed-priority grant (flush/inv/cpu), evaluated in IDLE only.

## Test plan
- Read miss at 0x0001000, MRDD=0xDEADBEEF after 4 cycles -> FILL with CTS=1, CWRM=F; CPUACK with CPURDD=0xDEADBEEF; repeat read -> hit, CPUACK at cycle 3, no MREQ.
- Write hit, CPUM=4'b0011, CPUWD=0x12345678 -> CWR with CTS=0, CWRM=3, then MEMWR with MM=3; CPUACK one cycle after MACK.
- Write miss, CPUM=F: with L2_WRITE_ALLOCATE_EN -> CWR+CTS pulse; without -> no CWR.
- FLUSH pulse during MEMRD -> fill completes, then CCLR=CALL=1 one cycle; FLUSHBUSY high throughout, low next cycle.
- FLUSH, INVREQ (INVA=0x0000040), CPUREQ simultaneous in IDLE -> order flush, invalidate (CALL=0, CWRA=0x40), then CPU.
- RST asserted while MREQ high -> next cycle all outputs 0, state IDLE, no CPUACK.
